// File: rtl/sram_port_arb.sv
// sram_port_arb: single-port SRAM arbiter; boot writes take absolute priority, CPU i/d buses share round-robin.
// Optional 16-bit grant/stall statistics counters are built when SRAM_ARB_STATS_EN is defined.
module sram_port_arb #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                boot_valid,
  input  logic [ADDR_W-1:0]   boot_addr,
  input  logic [DATA_W-1:0]   boot_wdata,
  input  logic [DATA_W/8-1:0] boot_wstrb,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ready,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ready,
  output logic                sram_valid,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [DATA_W-1:0]   sram_wdata,
  output logic [DATA_W/8-1:0] sram_wstrb,
  input  logic [DATA_W-1:0]   sram_rdata,
  input  logic                stats_clr,
  output logic [15:0]         stat_i_gnt,
  output logic [15:0]         stat_d_gnt,
  output logic [15:0]         stat_stall
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t r_state;
  logic   r_last_d;
  logic   r_i_ready;
  logic   r_d_ready;
  logic   w_boot;
  logic   w_cpu;
  logic   w_gnt_d;
  assign w_boot  = rst && boot_valid;
  assign w_cpu   = rst && !boot_valid && (r_state == IDLE) && (i_valid || d_valid);
  // With both masters requesting, d wins only if i was granted last.
  assign w_gnt_d = d_valid && (!i_valid || !r_last_d);
  always_comb begin
    sram_valid = w_boot || w_cpu;
    sram_addr  = w_boot ? boot_addr : w_cpu ? (w_gnt_d ? d_addr : i_addr) : '0;
    sram_wdata = w_boot ? boot_wdata : (w_cpu && w_gnt_d) ? d_wdata : '0;
    sram_wstrb = w_boot ? boot_wstrb : (w_cpu && w_gnt_d) ? d_wstrb : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b1;
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
    end else begin
      r_state   <= w_cpu ? WAIT : IDLE;
      r_i_ready <= w_cpu && !w_gnt_d;
      r_d_ready <= w_cpu && w_gnt_d;
      if (w_cpu) r_last_d <= w_gnt_d;
    end
  end
  assign i_ready = r_i_ready;
  assign d_ready = r_d_ready;
  assign i_rdata = sram_rdata;
  assign d_rdata = sram_rdata;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0] r_stat_i;
  logic [15:0] r_stat_d;
  logic [15:0] r_stat_s;
  logic        w_stall;
  // One stall count per cycle in which any valid master goes ungranted.
  assign w_stall = (i_valid && !(w_cpu && !w_gnt_d)) || (d_valid && !(w_cpu && w_gnt_d));
  always_ff @(posedge clk) begin
    if (!rst || stats_clr) begin
      r_stat_i <= '0;
      r_stat_d <= '0;
      r_stat_s <= '0;
    end else begin
      if (w_cpu && !w_gnt_d && r_stat_i != 16'hFFFF) r_stat_i <= r_stat_i + 16'd1;
      if (w_cpu && w_gnt_d && r_stat_d != 16'hFFFF) r_stat_d <= r_stat_d + 16'd1;
      if (w_stall && r_stat_s != 16'hFFFF) r_stat_s <= r_stat_s + 16'd1;
    end
  end
  assign stat_i_gnt = r_stat_i;
  assign stat_d_gnt = r_stat_d;
  assign stat_stall = r_stat_s;
`else
  logic w_unused_clr;
  assign w_unused_clr = stats_clr;
  assign stat_i_gnt   = '0;
  assign stat_d_gnt   = '0;
  assign stat_stall   = '0;
`endif
endmodule

// File: tb/tb_sram_port_arb.sv
// tb_sram_port_arb: directed scenarios plus randomized traffic against a transaction-level model.
module tb_sram_port_arb;
  logic        clk = 1'b0;
  logic        rst, boot_valid, i_valid, d_valid, stats_clr;
  logic [31:0] boot_addr, boot_wdata, i_addr, d_addr, d_wdata;
  logic [3:0]  boot_wstrb, d_wstrb;
  logic [31:0] i_rdata, d_rdata, sram_addr, sram_wdata, sram_rdata;
  logic [3:0]  sram_wstrb;
  logic        i_ready, d_ready, sram_valid;
  logic [15:0] stat_i_gnt, stat_d_gnt, stat_stall;
  int          n_tests = 0;
  int          n_fail = 0;
  always #5 clk = ~clk;
  sram_port_arb dut (
    .clk(clk), .rst(rst),
    .boot_valid(boot_valid), .boot_addr(boot_addr), .boot_wdata(boot_wdata), .boot_wstrb(boot_wstrb),
    .i_valid(i_valid), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .sram_valid(sram_valid), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_wstrb(sram_wstrb), .sram_rdata(sram_rdata),
    .stats_clr(stats_clr), .stat_i_gnt(stat_i_gnt), .stat_d_gnt(stat_d_gnt), .stat_stall(stat_stall)
  );
  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b+:8] = n[8*b+:8];
    return o;
  endfunction
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (sram_valid) begin
      if (sram_wstrb == 4'h0) sram_rdata <= mem[sram_addr[9:2]];
      else mem[sram_addr[9:2]] <= merge(mem[sram_addr[9:2]], sram_wdata, sram_wstrb);
    end
  end
  logic [31:0] ref_mem [0:255];
  logic        m_pend_i, m_pend_d, m_last_d, m_rd;
  logic [31:0] m_rdata;
  logic [15:0] m_si, m_sd, m_ss;
  logic        s_rst, s_bv, s_iv, s_dv, s_clr;
  logic [31:0] s_ba, s_bd, s_dd;
  logic [3:0]  s_bs, s_ds;
  logic        e_v, e_ri, e_rd;
  logic [31:0] e_a, e_wd;
  logic [3:0]  e_ws;
  int          e_g;
  task automatic eval();
    #1;
    {s_rst, s_bv, s_iv, s_dv, s_clr} = {rst, boot_valid, i_valid, d_valid, stats_clr};
    {s_ba, s_bd, s_bs, s_dd, s_ds} = {boot_addr, boot_wdata, boot_wstrb, d_wdata, d_wstrb};
    e_ri = m_pend_i;
    e_rd = m_pend_d;
    e_g  = 0;
    {e_v, e_a, e_wd, e_ws} = '0;
    if (rst && boot_valid) {e_v, e_a, e_wd, e_ws} = {1'b1, boot_addr, boot_wdata, boot_wstrb};
    else if (rst && !m_pend_i && !m_pend_d && (i_valid || d_valid)) begin
      e_g  = (i_valid && d_valid) ? (m_last_d ? 1 : 2) : (d_valid ? 2 : 1);
      e_v  = 1'b1;
      e_a  = (e_g == 2) ? d_addr : i_addr;
      e_wd = (e_g == 2) ? d_wdata : 32'h0;
      e_ws = (e_g == 2) ? d_wstrb : 4'h0;
    end
  endtask
  task automatic adv();
    @(negedge clk);
    if (!s_rst) begin
      {m_pend_i, m_pend_d, m_last_d} = 3'b001;
      {m_si, m_sd, m_ss} = '0;
    end else begin
      if (s_bv) ref_mem[s_ba[9:2]] = merge(ref_mem[s_ba[9:2]], s_bd, s_bs);
      m_pend_i = (e_g == 1);
      m_pend_d = (e_g == 2);
      if (e_g != 0) begin
        m_last_d = (e_g == 2);
        m_rd     = (e_g == 1) || (s_ds == 4'h0);
        m_rdata  = ref_mem[e_a[9:2]];
        if (e_g == 2 && s_ds != 4'h0) ref_mem[e_a[9:2]] = merge(ref_mem[e_a[9:2]], s_dd, s_ds);
      end
      if (s_clr) {m_si, m_sd, m_ss} = '0;
      else begin
        if (e_g == 1 && m_si != 16'hFFFF) m_si++;
        if (e_g == 2 && m_sd != 16'hFFFF) m_sd++;
        if (((s_iv && e_g != 1) || (s_dv && e_g != 2)) && m_ss != 16'hFFFF) m_ss++;
      end
    end
  endtask
  task automatic test_reset();
    eval();
    adv();
    for (int c = 0; c < 3; c++) begin
      eval();
      n_tests++;
      if ({sram_valid, i_ready, d_ready} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d got v/ir/dr=%b%b%b exp 000", c, sram_valid, i_ready, d_ready);
      end
      adv();
    end
    {rst, boot_valid} = 2'b10;
    eval();
    n_tests++;
    if ({sram_valid, sram_addr, sram_wstrb} !== {1'b1, 32'h200, 4'h0}) begin
      n_fail++;
      $display("FAIL reset_first_gnt got v=%b a=%h ws=%h exp v=1 a=200 ws=0", sram_valid, sram_addr, sram_wstrb);
    end
`ifndef SRAM_ARB_STATS_EN
    n_tests++;
    if ({stat_i_gnt, stat_d_gnt, stat_stall} !== 48'h0) begin
      n_fail++;
      $display("FAIL stats_tied got %h/%h/%h exp 0", stat_i_gnt, stat_d_gnt, stat_stall);
    end
`endif
    adv();
    {i_valid, d_valid} = 2'b00;
    eval();
    n_tests++;
    if ({i_ready, d_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_i_ready got ir/dr=%b%b exp 10", i_ready, d_ready);
    end
    adv();
  endtask
  task automatic test_boot_stream();
    {i_valid, i_addr, boot_wstrb} = {1'b1, 32'h200, 4'hF};
    for (int k = 0; k < 256; k++) begin
      {boot_valid, boot_addr, boot_wdata} = {1'b1, 32'(k * 4), 32'(k * 4 + 32'h100)};
      eval();
      n_tests++;
      if ({sram_valid, sram_addr, sram_wdata, sram_wstrb, i_ready} !== {1'b1, 32'(k * 4), 32'(k * 4 + 32'h100), 4'hF, 1'b0}) begin
        n_fail++;
        $display("FAIL boot_write k=%0d got v=%b a=%h wd=%h ws=%h ir=%b exp a=%h wd=%h", k, sram_valid,
                 sram_addr, sram_wdata, sram_wstrb, i_ready, k * 4, k * 4 + 32'h100);
      end
      adv();
    end
    boot_valid = 1'b0;
    eval();
    n_tests++;
    if ({sram_valid, sram_addr, sram_wstrb} !== {1'b1, 32'h200, 4'h0}) begin
      n_fail++;
      $display("FAIL boot_then_i got v=%b a=%h ws=%h exp v=1 a=200 ws=0", sram_valid, sram_addr, sram_wstrb);
    end
    adv();
    i_valid = 1'b0;
    eval();
    n_tests++;
    if ({i_ready, i_rdata} !== {1'b1, 32'h300}) begin
      n_fail++;
      $display("FAIL boot_readback got ir=%b rd=%h exp ir=1 rd=300", i_ready, i_rdata);
    end
    adv();
  endtask
  task automatic test_round_robin();
    {boot_valid, boot_addr, boot_wdata, boot_wstrb} = {1'b1, 32'h80, 32'hDEADBEEF, 4'hF};
    eval();
    adv();
    boot_valid = 1'b0;
    {i_valid, i_addr, d_valid, d_addr, d_wstrb} = {1'b1, 32'h40, 1'b1, 32'h80, 4'h0};
    for (int c = 0; c < 8; c++) begin
      eval();
      n_tests++;
      if ((c % 2 == 0) ? ({sram_valid, sram_addr} !== {1'b1, (c % 4 == 0) ? 32'h80 : 32'h40}) : (sram_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL rr_issue cyc=%0d got v=%b a=%h", c, sram_valid, sram_addr);
      end
      n_tests++;
      if ({i_ready, d_ready} !== {c % 4 == 3, c % 4 == 1}) begin
        n_fail++;
        $display("FAIL rr_ready cyc=%0d got ir/dr=%b%b", c, i_ready, d_ready);
      end
      if (c % 4 == 1) begin
        n_tests++;
        if (d_rdata !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL rr_d_rdata got %h exp deadbeef", d_rdata);
        end
      end
      if (c % 4 == 3) begin
        n_tests++;
        if (i_rdata !== 32'h140) begin
          n_fail++;
          $display("FAIL rr_i_rdata got %h exp 140", i_rdata);
        end
      end
      adv();
    end
    {i_valid, d_valid} = 2'b00;
  endtask
  task automatic test_data_write();
    int pulses = 0;
    {boot_valid, boot_addr, boot_wdata, boot_wstrb} = {1'b1, 32'h10, 32'h0, 4'hF};
    eval();
    adv();
    boot_valid = 1'b0;
    {d_valid, d_addr, d_wdata, d_wstrb} = {1'b1, 32'h10, 32'hA5A5A5A5, 4'b0011};
    for (int c = 0; c < 5; c++) begin
      if (c == 2) d_wstrb = 4'h0;
      if (c == 4) d_valid = 1'b0;
      eval();
      pulses += int'(d_ready);
      if (c == 0 || c == 2) begin
        n_tests++;
        if ({sram_valid, sram_addr, sram_wdata, sram_wstrb} !== {1'b1, 32'h10, 32'hA5A5A5A5, (c == 0) ? 4'b0011 : 4'h0}) begin
          n_fail++;
          $display("FAIL dw_issue cyc=%0d got v=%b a=%h wd=%h ws=%h", c, sram_valid, sram_addr, sram_wdata, sram_wstrb);
        end
      end
      if (c == 3) begin
        n_tests++;
        if ({d_ready, d_rdata} !== {1'b1, 32'h0000A5A5}) begin
          n_fail++;
          $display("FAIL dw_readback got dr=%b rd=%h exp dr=1 rd=0000a5a5", d_ready, d_rdata);
        end
      end
      adv();
    end
    n_tests++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL dw_ready_pulses got %0d exp 2", pulses);
    end
  endtask
  task automatic test_boot_in_wait();
    {i_valid, i_addr} = {1'b1, 32'h44};
    eval();
    n_tests++;
    if ({sram_valid, sram_addr} !== {1'b1, 32'h44}) begin
      n_fail++;
      $display("FAIL biw_grant got v=%b a=%h exp v=1 a=44", sram_valid, sram_addr);
    end
    adv();
    {boot_valid, boot_addr, boot_wdata, boot_wstrb} = {1'b1, 32'h300, 32'hCAFEF00D, 4'hF};
    eval();
    n_tests++;
    if ({i_ready, i_rdata, sram_valid, sram_addr, sram_wdata, sram_wstrb} !== {1'b1, 32'h144, 1'b1, 32'h300, 32'hCAFEF00D, 4'hF}) begin
      n_fail++;
      $display("FAIL biw_overlap got ir=%b rd=%h v=%b a=%h wd=%h ws=%h exp ir=1 rd=144 a=300", i_ready, i_rdata,
               sram_valid, sram_addr, sram_wdata, sram_wstrb);
    end
    adv();
    boot_valid = 1'b0;
    eval();
    n_tests++;
    if ({sram_valid, sram_addr, sram_wstrb, i_ready} !== {1'b1, 32'h44, 4'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL biw_regrant got v=%b a=%h ws=%h ir=%b exp v=1 a=44 ws=0 ir=0", sram_valid, sram_addr, sram_wstrb, i_ready);
    end
    adv();
    i_valid = 1'b0;
    eval();
    n_tests++;
    if ({i_ready, i_rdata} !== {1'b1, 32'h144}) begin
      n_fail++;
      $display("FAIL biw_second got ir=%b rd=%h exp ir=1 rd=144", i_ready, i_rdata);
    end
    adv();
  endtask
  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom % 100) != 0;
      stats_clr = ($urandom % 32) == 0;
      {boot_valid, boot_addr, boot_wdata, boot_wstrb} = {($urandom % 4) == 0, 32'(($urandom % 256) * 4), 32'($urandom), 4'($urandom)};
      if (!i_valid || e_ri) {i_valid, i_addr} = {1'($urandom), 32'(($urandom % 256) * 4)};
      if (!d_valid || e_rd) begin
        {d_valid, d_addr, d_wdata} = {1'($urandom), 32'(($urandom % 256) * 4), 32'($urandom)};
        d_wstrb = ($urandom % 2) ? 4'h0 : 4'($urandom);
      end
      eval();
      n_tests++;
      if ({sram_valid, sram_addr, sram_wdata, sram_wstrb} !== {e_v, e_a, e_wd, e_ws}) begin
        n_fail++;
        $display("FAIL rnd_issue cyc=%0d got v=%b a=%h wd=%h ws=%h exp v=%b a=%h wd=%h ws=%h", c, sram_valid,
                 sram_addr, sram_wdata, sram_wstrb, e_v, e_a, e_wd, e_ws);
      end
      n_tests++;
      if ({i_ready, d_ready} !== {e_ri, e_rd}) begin
        n_fail++;
        $display("FAIL rnd_ready cyc=%0d got ir/dr=%b%b exp %b%b", c, i_ready, d_ready, e_ri, e_rd);
      end
      if ((e_ri || e_rd) && m_rd) begin
        n_tests++;
        if ((e_ri ? i_rdata : d_rdata) !== m_rdata) begin
          n_fail++;
          $display("FAIL rnd_rdata cyc=%0d got %h exp %h", c, e_ri ? i_rdata : d_rdata, m_rdata);
        end
      end
`ifdef SRAM_ARB_STATS_EN
      n_tests++;
      if ({stat_i_gnt, stat_d_gnt, stat_stall} !== {m_si, m_sd, m_ss}) begin
        n_fail++;
        $display("FAIL rnd_stats cyc=%0d got %0d/%0d/%0d exp %0d/%0d/%0d", c, stat_i_gnt, stat_d_gnt,
                 stat_stall, m_si, m_sd, m_ss);
      end
`endif
      adv();
    end
  endtask
  initial begin
    {rst, stats_clr, boot_valid, i_valid, d_valid} = 5'b00111;
    {boot_addr, boot_wdata, boot_wstrb} = {32'h0, 32'h0, 4'hF};
    {i_addr, d_addr, d_wdata, d_wstrb} = {32'h200, 32'h204, 32'h0, 4'h0};
    test_reset();
    test_boot_stream();
    test_round_robin();
    test_data_write();
    test_boot_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
